ram_readback_unpacker: RTL and testbench

//  Drains the capture RAM after a test run. Reads burst words in address order and splits

---
 rtl/ram_readback_unpacker_pkg.sv | 30 +++
 rtl/ram_readback_unpacker_if.sv | 28 ++
 rtl/ram_readback_unpacker_burst_slot_mux.sv | 46 ++++
 rtl/ram_readback_unpacker.sv | 114 +++++++++++
 tb/tb_ram_readback_unpacker.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_readback_unpacker_pkg.sv
// Shared definitions for the capture-RAM readback unpacker.
// Holds the operand/sample geometry, the RAM word layout, the FSM state
// encoding and the widths derived from them.
package ram_readback_unpacker_pkg;

  localparam int no_of_digits            = 10;
  localparam int radix_bits              = 3;
  localparam int burst_index             = 5;
  localparam int address_width           = 14;
  localparam int max_ram_address_default = 4096;
  localparam int ram_latency_default     = 2;

  // One unpacked sample is {cout, dout}; a RAM word packs burst_index of them.
  localparam int sample_w = (no_of_digits + 1) * radix_bits;
  localparam int word_w   = sample_w * burst_index;
  localparam int index_w  = address_width + 3;
  localparam int slot_w   = (burst_index > 1) ? $clog2(burst_index) : 1;

  typedef logic [sample_w-1:0] sample_t;
  typedef logic [word_w-1:0]   word_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    EMIT,
    DONE
  } state_t;

endpackage

// File: rtl/ram_readback_unpacker_if.sv
// RAM read bus plus sample stream of the readback unpacker.
//   ram_addr      read address towards the capture RAM
//   mem_read      RAM read data (burst word)
//   sample_out    one unpacked sample
//   sample_valid  sample_out holds a sample
//   sample_ready  consumer accepts when valid & ready
//   sample_index  running 0-based sample number
// master: the unpacker side. slave: the RAM + result-export side.
interface ram_readback_unpacker_if;
  import ram_readback_unpacker_pkg::*;

  logic [address_width-1:0] ram_addr;
  word_t                    mem_read;
  sample_t                  sample_out;
  logic                     sample_valid;
  logic                     sample_ready;
  logic [index_w-1:0]       sample_index;

  modport master (
    output ram_addr, sample_out, sample_valid, sample_index,
    input  mem_read, sample_ready
  );

  modport slave (
    input  ram_addr, sample_out, sample_valid, sample_index,
    output mem_read, sample_ready
  );
endinterface

// File: rtl/ram_readback_unpacker_burst_slot_mux.sv
// Hold register for one RAM burst word plus a combinational slot selector.
//   clk      RAM-domain clock
//   reset_n  synchronous active-low reset, clears the hold register
//   load     capture word_in into the hold register
//   word_in  RAM read data
//   slot     slot number to present (0 = lowest bits)
//   sample   selected slot of the held word
module ram_readback_unpacker_burst_slot_mux
  import ram_readback_unpacker_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  word_t             word_in,
  input  logic [slot_w-1:0] slot,
  output sample_t           sample
);

  word_t   hold_reg;
  sample_t slot_arr [burst_index];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_reg <= '0;
    end else if (load) begin
      hold_reg <= word_in;
    end
  end

  generate
    for (genvar gi = 0; gi < burst_index; gi++) begin : g_slot
      assign slot_arr[gi] = hold_reg[gi*sample_w +: sample_w];
    end
  endgenerate

  // Compare-based select keeps unused slot codes from indexing past the array.
  always_comb begin
    sample = '0;
    for (int i = 0; i < burst_index; i++) begin
      if (slot == slot_w'(i)) begin
        sample = slot_arr[i];
      end
    end
  end

endmodule

// File: rtl/ram_readback_unpacker.sv
// Drains the capture RAM after a test run: reads words in address order,
// splits each into burst_index samples (slot 0 first) and streams them with
// a valid/ready handshake to the result-export path.
//   clk      RAM-domain clock
//   reset_n  synchronous active-low reset
//   start    begin a drain (only honoured in IDLE or DONE)
//   bus      RAM read bus and sample stream (master side)
//   busy     high from start acceptance until DONE
//   done     high while in DONE
module ram_readback_unpacker
  import ram_readback_unpacker_pkg::*;
#(
  parameter int max_ram_address = max_ram_address_default,
  parameter int ram_latency     = ram_latency_default
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  ram_readback_unpacker_if.master bus,
  output logic                    busy,
  output logic                    done
);

  localparam int wait_w = $clog2(ram_latency + 1);
  localparam logic [address_width-1:0] last_addr = address_width'(max_ram_address - 1);
  localparam logic [slot_w-1:0]        last_slot = slot_w'(burst_index - 1);

  state_t                   state_reg, state_next;
  logic [address_width-1:0] addr_reg, addr_next;
  logic [index_w-1:0]       index_reg, index_next;
  logic [slot_w-1:0]        slot_reg, slot_next;
  logic [wait_w-1:0]        wait_reg, wait_next;
  logic                     load_hold;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      index_reg <= '0;
      slot_reg  <= '0;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      index_reg <= index_next;
      slot_reg  <= slot_next;
      wait_reg  <= wait_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    index_next = index_reg;
    slot_next  = slot_reg;
    wait_next  = wait_reg;
    load_hold  = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = READ;
          addr_next  = '0;
          index_next = '0;
        end
      end
      READ: begin
        // Address is already on ram_addr; wait out the RAM pipeline.
        wait_next  = wait_w'(ram_latency - 1);
        state_next = WAIT;
      end
      WAIT: begin
        if (wait_reg == '0) begin
          load_hold  = 1'b1;
          slot_next  = '0;
          state_next = EMIT;
        end else begin
          wait_next = wait_reg - 1'b1;
        end
      end
      EMIT: begin
        if (bus.sample_ready) begin
          index_next = index_reg + 1'b1;
          if (slot_reg == last_slot) begin
            if (addr_reg == last_addr) begin
              state_next = DONE;
            end else begin
              addr_next  = addr_reg + 1'b1;
              state_next = READ;
            end
          end else begin
            slot_next = slot_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  ram_readback_unpacker_burst_slot_mux u_slot_mux (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load_hold),
    .word_in (bus.mem_read),
    .slot    (slot_reg),
    .sample  (bus.sample_out)
  );

  assign bus.ram_addr     = addr_reg;
  assign bus.sample_index = index_reg;
  assign bus.sample_valid = (state_reg == EMIT);
  assign busy             = (state_reg == READ) || (state_reg == WAIT) || (state_reg == EMIT);
  assign done             = (state_reg == DONE);

endmodule

// File: tb/tb_ram_readback_unpacker.sv
// Bench for ram_readback_unpacker with a 4-word RAM, 2-cycle read latency.
// RAM word a carries value (a<<8)|k in slot k. A reference model tracks the
// drain as "n-th transfer of the current run" and the monitor compares the
// DUT against it on every falling edge.
module tb_ram_readback_unpacker;
  import ram_readback_unpacker_pkg::*;

  localparam int max_addr = 4;
  localparam int total    = max_addr * burst_index;

  typedef enum {PH_IDLE, PH_RUN, PH_DONE} ph_t;

  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic busy, done;

  ram_readback_unpacker_if bus ();

  ram_readback_unpacker #(
    .max_ram_address (max_addr),
    .ram_latency     (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // RAM model: two register stages between address and data.
  logic [address_width-1:0] addr_d1;
  word_t                    q_reg;

  function automatic word_t ram_word(input logic [address_width-1:0] a);
    word_t w;
    w = '0;
    for (int k = 0; k < burst_index; k++) begin
      w[k*sample_w +: sample_w] = sample_t'((int'(a) << 8) | k);
    end
    return w;
  endfunction

  always @(posedge clk) begin
    addr_d1 <= bus.ram_addr;
    q_reg   <= ram_word(addr_d1);
  end
  assign bus.mem_read = q_reg;

  // Expected n-th sample of a drain: word n/burst_index, slot n%burst_index.
  function automatic sample_t exp_sample(input int n);
    return sample_t'(((n / burst_index) << 8) | (n % burst_index));
  endfunction

  int      checks = 0;
  int      errors = 0;
  ph_t     m_phase = PH_IDLE;
  int      exp_n = 0;
  bit      rst_applied = 1'b0;
  bit      prev_stall = 1'b0;
  sample_t log_arr [total];
  int      ready_mode = 0;  // 0: high, 1: toggle, 2: random

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h exp_n=%0d t=%0t", name, act, req, exp_n, $time);
    end
  endtask

  // Monitor: check against the model, then advance the model with the inputs
  // the DUT will sample at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_applied) begin
        check("rst_ram_addr", 64'(bus.ram_addr), 64'd0);
        check("rst_sample_out", 64'(bus.sample_out), 64'd0);
        check("rst_sample_index", 64'(bus.sample_index), 64'd0);
      end
      case (m_phase)
        PH_IDLE: begin
          check("idle_valid", 64'(bus.sample_valid), 64'd0);
          check("idle_busy", 64'(busy), 64'd0);
          check("idle_done", 64'(done), 64'd0);
        end
        PH_RUN: begin
          check("run_busy", 64'(busy), 64'd1);
          check("run_done", 64'(done), 64'd0);
          if (prev_stall) check("valid_held", 64'(bus.sample_valid), 64'd1);
          if (bus.sample_valid === 1'b1) begin
            check("sample_out", 64'(bus.sample_out), 64'(exp_sample(exp_n)));
            check("sample_index", 64'(bus.sample_index), 64'(exp_n));
            check("ram_addr", 64'(bus.ram_addr), 64'(exp_n / burst_index));
          end
        end
        PH_DONE: begin
          check("done_done", 64'(done), 64'd1);
          check("done_busy", 64'(busy), 64'd0);
          check("done_valid", 64'(bus.sample_valid), 64'd0);
          check("done_ram_addr", 64'(bus.ram_addr), 64'(max_addr - 1));
        end
        default: ;
      endcase
      prev_stall = (m_phase == PH_RUN) && bus.sample_valid && !bus.sample_ready && reset_n;
      if (!reset_n) begin
        m_phase     = PH_IDLE;
        exp_n       = 0;
        rst_applied = 1'b1;
        prev_stall  = 1'b0;
      end else begin
        rst_applied = 1'b0;
        if (start && m_phase != PH_RUN) begin
          m_phase = PH_RUN;
          exp_n   = 0;
        end else if (m_phase == PH_RUN && bus.sample_valid && bus.sample_ready) begin
          log_arr[exp_n] = bus.sample_out;
          exp_n++;
          if (exp_n == total) m_phase = PH_DONE;
        end
      end
    end
  end

  // Consumer ready pattern.
  initial begin
    bus.sample_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.sample_ready = 1'b1;
        1:       bus.sample_ready = ~bus.sample_ready;
        default: bus.sample_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int cyc = 0;
    while (m_phase != PH_DONE && cyc < 1000) begin
      @(posedge clk);
      cyc++;
    end
    checks++;
    if (m_phase != PH_DONE) begin
      errors++;
      $display("FAIL %s_timeout transfers=%0d required=%0d", tag, exp_n, total);
    end
    $display("%s: drain finished after %0d cycles, %0d transfers", tag, cyc, exp_n);
  endtask

  task automatic wait_transfers(input int n, input string tag);
    int cyc = 0;
    while (exp_n < n && cyc < 1000) begin
      @(posedge clk);
      cyc++;
    end
    checks++;
    if (exp_n < n) begin
      errors++;
      $display("FAIL %s_timeout transfers=%0d required=%0d", tag, exp_n, n);
    end
  endtask

  initial begin
    // T1: reset held with start high; reset wins.
    reset_n = 1'b0;
    start   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b1;
    start   = 1'b0;
    repeat (3) @(posedge clk);
    $display("T1: reset with start held, outputs idle");

    // T2: full drain, ready held high.
    ready_mode = 0;
    pulse_start();
    wait_drain("T2");
    check("pin_sample0", 64'(log_arr[0]), 64'h0);
    check("pin_sample7", 64'(log_arr[7]), 64'h102);
    check("pin_sample19", 64'(log_arr[19]), 64'h304);
    check("pin_model13", 64'(exp_sample(13)), 64'h203);
    repeat (3) @(posedge clk);

    // T3: backpressure, ready toggling.
    ready_mode = 1;
    pulse_start();
    wait_drain("T3");
    check("T3_pin_sample11", 64'(log_arr[11]), 64'h201);

    // T4: start while busy is ignored.
    ready_mode = 2;
    pulse_start();
    wait_transfers(7, "T4");
    pulse_start();
    $display("T4: start pulsed at transfer %0d", exp_n);
    wait_drain("T4");

    // T5: reset mid-drain, then restart from address 0.
    ready_mode = 0;
    pulse_start();
    wait_transfers(12, "T5");
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    $display("T5: reset applied mid-drain");
    repeat (2) @(posedge clk);
    pulse_start();
    wait_drain("T5");

    // T6: start from DONE runs an identical second drain.
    ready_mode = 2;
    pulse_start();
    wait_drain("T6");
    check("T6_pin_sample19", 64'(log_arr[19]), 64'h304);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout time=%0t", $time);
    $fatal(1, "global timeout");
  end

endmodule
